// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_ADDR_W   = 5;

    // One buffered result: destination register and value
    typedef struct packed {
        logic [REG_ADDR_W-1:0]   rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_entry_t;

    // Source served by the most recent grant
    typedef enum logic {
        SrcAlu = 1'b0,
        SrcMem = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding writeback entries for one result source.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_push_data,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output T     o_head
);

    localparam int unsigned    PW       = $clog2(DEPTH);
    localparam logic [PW:0]    CNT_FULL = (PW + 1)'(DEPTH);

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_count;

    logic            w_push;
    logic            w_pop;

    // A full buffer refuses pushes; an empty one ignores pops
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rptr];

    // Payload storage, no reset needed: validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter merging ALU and load results onto one register-file
// write port. Each source is buffered in its own wb_fifo.
// Optional forwarding query enabled by defining WB_FORWARD_EN.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = XLEN_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic                  write_en,
    output logic [REG_ADDR_W-1:0] write_ptr,
    output logic [XLEN-1:0]       write_data,
    input  logic [REG_ADDR_W-1:0] fwd_ptr,
    output logic                  fwd_hit,
    output logic [XLEN-1:0]       fwd_data
);

    // Same layout as wb_entry_t, sized by this instance's XLEN
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t                w_alu_in;
    entry_t                w_mem_in;
    entry_t                w_alu_head;
    entry_t                w_mem_head;
    entry_t                w_head;
    logic                  w_alu_full;
    logic                  w_alu_empty;
    logic                  w_mem_full;
    logic                  w_mem_empty;
    logic                  w_grant_alu;
    logic                  w_grant_mem;

    wb_src_e               r_last_grant;
    logic                  r_write_en;
    logic [REG_ADDR_W-1:0] r_write_ptr;
    logic [XLEN-1:0]       r_write_data;

    assign w_alu_in = '{rd: alu_rd, data: alu_data};
    assign w_mem_in = '{rd: mem_rd, data: mem_data};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (alu_valid),
        .i_push_data (w_alu_in),
        .i_pop       (w_grant_alu),
        .o_full      (w_alu_full),
        .o_empty     (w_alu_empty),
        .o_head      (w_alu_head)
    );

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_mem_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (mem_valid),
        .i_push_data (w_mem_in),
        .i_pop       (w_grant_mem),
        .o_full      (w_mem_full),
        .o_empty     (w_mem_empty),
        .o_head      (w_mem_head)
    );

    // Ready reflects buffer state only, never a same-cycle pop
    assign alu_ready = !w_alu_full;
    assign mem_ready = !w_mem_full;

    // Round-robin: a lone head always wins; on contention the source not served last wins
    assign w_grant_mem = !w_mem_empty && (w_alu_empty || (r_last_grant == SrcAlu));
    assign w_grant_alu = !w_alu_empty && (w_mem_empty || (r_last_grant == SrcMem));
    assign w_head      = w_grant_mem ? w_mem_head : w_alu_head;

    // Register the write port; an x0 destination is consumed but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= SrcAlu;
            r_write_en   <= 1'b0;
            r_write_ptr  <= '0;
            r_write_data <= '0;
        end else if (w_grant_alu || w_grant_mem) begin
            r_last_grant <= w_grant_mem ? SrcMem : SrcAlu;
            r_write_en   <= (w_head.rd != '0);
            r_write_ptr  <= w_head.rd;
            r_write_data <= w_head.data;
        end else begin
            r_write_en   <= 1'b0;
        end
    end

    assign write_en   = r_write_en;
    assign write_ptr  = r_write_ptr;
    assign write_data = r_write_data;

`ifdef WB_FORWARD_EN
    // Forward the value being written this cycle; x0 never hits
    assign fwd_hit  = r_write_en && (fwd_ptr == r_write_ptr) && (fwd_ptr != '0);
    assign fwd_data = fwd_hit ? r_write_data : '0;
`else
    logic w_unused_fwd_ptr;
    assign w_unused_fwd_ptr = ^fwd_ptr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (FIFO_DEPTH=2, XLEN=32).
module tb_writeback_arbiter;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        write_en;
    logic [4:0]  write_ptr;
    logic [31:0] write_data;
    logic [4:0]  fwd_ptr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int n_chk = 0;
    int n_err = 0;

    logic [4:0]  e_ptr  [16];
    logic [31:0] e_data [16];

    writeback_arbiter #(
        .FIFO_DEPTH (2),
        .XLEN       (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .write_en   (write_en),
        .write_ptr  (write_ptr),
        .write_data (write_data),
        .fwd_ptr    (fwd_ptr),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'd0;
    endtask

    // Offer na ALU / nm MEM entries as fast as ready allows and compare every
    // write against e_ptr/e_data; writes must be back-to-back.
    task automatic run_stream(input string tag, input int na, input int nm,
                              input logic [4:0] ard, input logic [4:0] mrd,
                              input logic [31:0] abase, input logic [31:0] mbase,
                              input int nexp, input int bp_cycle);
        int   ai    = 0;
        int   mi    = 0;
        int   wi    = 0;
        int   first = -1;
        int   last  = -1;
        logic acc_a;
        logic acc_m;
        for (int cyc = 0; cyc < 20; cyc++) begin
            alu_valid = (ai < na);
            alu_rd    = ard + 5'(ai);
            alu_data  = abase + 32'(ai);
            mem_valid = (mi < nm);
            mem_rd    = mrd + 5'(mi);
            mem_data  = mbase + 32'(mi);
            acc_a     = alu_valid && alu_ready;
            acc_m     = mem_valid && mem_ready;
            step();
            if (acc_a) ai++;
            if (acc_m) mi++;
            if (ai >= na) alu_valid = 1'b0;
            if (mi >= nm) mem_valid = 1'b0;
            if (cyc == bp_cycle) chk({tag, "_alu_ready_full"}, 64'(alu_ready), 64'(0));
            if (write_en) begin
                if (wi < nexp) begin
                    chk($sformatf("%s_ptr%0d", tag, wi), 64'(write_ptr), 64'(e_ptr[wi]));
                    chk($sformatf("%s_data%0d", tag, wi), 64'(write_data), 64'(e_data[wi]));
                end
                if (first < 0) first = cyc;
                last = cyc;
                wi++;
            end
        end
        idle_inputs();
        chk({tag, "_write_count"}, 64'(wi), 64'(nexp));
        chk({tag, "_accepted"}, 64'(ai + mi), 64'(na + nm));
        chk({tag, "_back_to_back"}, 64'(last - first), 64'(nexp - 1));
    endtask

    initial begin
        idle_inputs();
        fwd_ptr = 5'd0;
        rst_n   = 1'b0;
        #1;
        chk("rst_write_en", 64'(write_en), 64'(0));
        chk("rst_write_ptr", 64'(write_ptr), 64'(0));
        chk("rst_write_data", 64'(write_data), 64'(0));
        chk("rst_alu_ready", 64'(alu_ready), 64'(1));
        chk("rst_mem_ready", 64'(mem_ready), 64'(1));
        chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Contention: MEM first (last_grant starts ALU), then strict alternation
        for (int i = 0; i < 4; i++) begin
            e_ptr[2*i]    = 5'(20 + i);
            e_data[2*i]   = 32'h100 + 32'(i);
            e_ptr[2*i+1]  = 5'(10 + i);
            e_data[2*i+1] = 32'd1 + 32'(i);
        end
        run_stream("contend", 4, 4, 5'd10, 5'd20, 32'd1, 32'h100, 8, -1);

        // Backpressure: last grant was ALU, so MEM wins first and ALU fills up
        e_ptr[0] = 5'd24; e_data[0] = 32'hB0;
        e_ptr[1] = 5'd1;  e_data[1] = 32'hA0;
        e_ptr[2] = 5'd25; e_data[2] = 32'hB1;
        e_ptr[3] = 5'd2;  e_data[3] = 32'hA1;
        e_ptr[4] = 5'd3;  e_data[4] = 32'hA2;
        run_stream("backpr", 3, 2, 5'd1, 5'd24, 32'hA0, 32'hB0, 5, 1);

        // Single ALU write: accepted at edge N, visible after edge N+1, one pulse
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        chk("single_ready", 64'(alu_ready), 64'(1));
        step();
        idle_inputs();
        chk("single_en_n", 64'(write_en), 64'(0));
        step();
        chk("single_en_n1", 64'(write_en), 64'(1));
        chk("single_ptr", 64'(write_ptr), 64'(5));
        chk("single_data", 64'(write_data), 64'(32'hDEADBEEF));
        step();
        chk("single_en_n2", 64'(write_en), 64'(0));
        chk("single_ptr_hold", 64'(write_ptr), 64'(5));
        chk("single_data_hold", 64'(write_data), 64'(32'hDEADBEEF));

        // Forwarding against an active write to r7
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'h77;
        step();
        idle_inputs();
        step();
        chk("fwd_write_en", 64'(write_en), 64'(1));
        fwd_ptr = 5'd7;
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd_hit_r7", 64'(fwd_hit), 64'(1));
        chk("fwd_data_r7", 64'(fwd_data), 64'(32'h77));
`else
        chk("fwd_hit_off", 64'(fwd_hit), 64'(0));
        chk("fwd_data_off", 64'(fwd_data), 64'(0));
`endif
        fwd_ptr = 5'd0;
        #1;
        chk("fwd_hit_r0", 64'(fwd_hit), 64'(0));
        chk("fwd_data_r0", 64'(fwd_data), 64'(0));
        step();

        // x0 destination: consumed, never written
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 32'h55;
        step();
        idle_inputs();
        step();
        chk("x0_en_grant", 64'(write_en), 64'(0));
        chk("x0_mem_ready", 64'(mem_ready), 64'(1));
        step();
        chk("x0_en_after", 64'(write_en), 64'(0));

        // Reset mid-operation with entries still buffered
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
        step();
        mem_valid = 1'b0;
        alu_rd = 5'd6; alu_data = 32'h66;
        step();
        idle_inputs();
        chk("rstmid_en_before", 64'(write_en), 64'(1));
        chk("rstmid_ptr_before", 64'(write_ptr), 64'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_en", 64'(write_en), 64'(0));
        chk("rstmid_ptr", 64'(write_ptr), 64'(0));
        chk("rstmid_data", 64'(write_data), 64'(0));
        chk("rstmid_alu_ready", 64'(alu_ready), 64'(1));
        chk("rstmid_mem_ready", 64'(mem_ready), 64'(1));
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rstmid_no_write%0d", i), 64'(write_en), 64'(0));
        end
        chk("rstmid_alu_ready_after", 64'(alu_ready), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
